// File: rtl/riscv_memory_pkg.sv
// Shared types and constants for the RV32I memory stage: data width, funct3 access codes,
// writeback source encodings, FSM states and the pipeline register layouts.
package riscv_memory_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_e;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      funct3;
        logic [1:0]      result_src;
    } ex_mem_t;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [4:0]      rd;
        logic [1:0]      result_src;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] read_data;
        logic [XLEN-1:0] pc_plus4;
    } mem_wb_t;

endpackage

// File: rtl/riscv_load_store_align.sv
// Combinational byte-lane steering: store enables/replication, load lane select with
// sign/zero extension, and alignment check for the access width.
module riscv_load_store_align
    import riscv_memory_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misalign
);

    logic            is_byte;
    logic            is_half;
    logic            is_unsigned;
    logic [XLEN-1:0] shifted;
    logic [3:0][7:0] wlane;

    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        case (funct3)
            F3_B, F3_BU: is_byte = 1'b1;
            F3_H, F3_HU: is_half = 1'b1;
            default:     ;
        endcase
    end

    assign is_unsigned = funct3[2];

    always_comb begin
        be       = 4'b1111;
        misalign = 1'b0;
        if (is_byte) begin
            be = 4'b0001 << addr_lo;
        end else if (is_half) begin
            be       = 4'b0011 << addr_lo;
            misalign = addr_lo[0];
        end else begin
            misalign = (addr_lo != 2'b00);
        end
    end

    // Each lane carries the store byte it would hold for any legal offset of this width.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wlane[gi] = is_byte ? store_data[7:0] :
                               is_half ? store_data[(gi % 2) * 8 +: 8] :
                                         store_data[gi * 8 +: 8];
        end
    endgenerate

    assign wdata   = wlane;
    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        if (is_byte) begin
            load_data = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
        end else if (is_half) begin
            load_data = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
        end else begin
            load_data = rdata;
        end
    end

endmodule

// File: rtl/riscv_memory.sv
// RV32I memory stage: EX/MEM and MEM/WB registers, a two-state access FSM with a bus
// timeout, and a ready-handshaked data-memory port.
module riscv_memory
    import riscv_memory_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_valid_e,
    input  logic [XLEN-1:0] i_alu_result_e,
    input  logic [XLEN-1:0] i_write_data_e,
    input  logic [XLEN-1:0] i_pc_plus4_e,
    input  logic [4:0]      i_rd_e,
    input  logic            i_reg_write_e,
    input  logic            i_mem_read_e,
    input  logic            i_mem_write_e,
    input  logic [2:0]      i_funct3_e,
    input  logic [1:0]      i_result_src_e,
    output logic [XLEN-1:0] o_alu_result_m,
    output logic [4:0]      o_rd_m,
    output logic            o_reg_write_m,
    output logic            o_stall_m,
    output logic            o_misalign_m,
    output logic            o_bus_err_m,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_ready,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_valid_w,
    output logic            o_reg_write_w,
    output logic [4:0]      o_rd_w,
    output logic [1:0]      o_result_src_w,
    output logic [XLEN-1:0] o_alu_result_w,
    output logic [XLEN-1:0] o_read_data_w,
    output logic [XLEN-1:0] o_pc_plus4_w
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    ex_mem_t         ex_mem_reg, ex_mem_next;
    mem_wb_t         mem_wb_reg, mem_wb_next;
    mem_state_e      state_reg, state_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

    logic            mem_op;
    logic            misalign;
    logic            timed_out;
    logic            req;
    logic            stall;
    logic            misalign_pulse;
    logic            bus_err;
    logic            retire;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] load_data;

    riscv_load_store_align u_align (
        .funct3     (ex_mem_reg.funct3),
        .addr_lo    (ex_mem_reg.alu_result[1:0]),
        .store_data (ex_mem_reg.write_data),
        .rdata      (i_dmem_rdata),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data),
        .misalign   (misalign)
    );

    assign mem_op    = ex_mem_reg.valid & (ex_mem_reg.mem_read | ex_mem_reg.mem_write);
    assign timed_out = (state_reg == M_WAIT) && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES));

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_reg    <= M_IDLE;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // FSM: next state; the counter holds the number of unready cycles seen so far
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            M_IDLE: begin
                if (stall) begin
                    state_next    = M_WAIT;
                    wait_cnt_next = CNT_W'(1);
                end
            end
            M_WAIT: begin
                if (timed_out || !stall) begin
                    state_next    = M_IDLE;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next    = M_IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        req            = mem_op & ~misalign & ~timed_out;
        stall          = req & ~i_dmem_ready;
        misalign_pulse = mem_op & misalign;
        bus_err        = mem_op & timed_out;
    end

    always_comb begin
        ex_mem_next            = ex_mem_reg;
        ex_mem_next.valid      = i_valid_e;
        ex_mem_next.alu_result = i_alu_result_e;
        ex_mem_next.write_data = i_write_data_e;
        ex_mem_next.pc_plus4   = i_pc_plus4_e;
        ex_mem_next.rd         = i_rd_e;
        ex_mem_next.reg_write  = i_reg_write_e;
        ex_mem_next.mem_read   = i_mem_read_e;
        ex_mem_next.mem_write  = i_mem_write_e;
        ex_mem_next.funct3     = i_funct3_e;
        ex_mem_next.result_src = i_result_src_e;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            ex_mem_reg <= '0;
        end else if (!stall) begin
            ex_mem_reg <= ex_mem_next;
        end
    end

    // Stalled, misaligned and timed-out slots all leave as bubbles
    assign retire = ex_mem_reg.valid & ~stall & ~misalign_pulse & ~bus_err;

    always_comb begin
        mem_wb_next.valid      = retire;
        mem_wb_next.reg_write  = retire & ex_mem_reg.reg_write;
        mem_wb_next.rd         = ex_mem_reg.rd;
        mem_wb_next.result_src = ex_mem_reg.result_src;
        mem_wb_next.alu_result = ex_mem_reg.alu_result;
        mem_wb_next.read_data  = ex_mem_reg.mem_read ? load_data : '0;
        mem_wb_next.pc_plus4   = ex_mem_reg.pc_plus4;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            mem_wb_reg <= '0;
        end else begin
            mem_wb_reg <= mem_wb_next;
        end
    end

    assign o_alu_result_m = ex_mem_reg.alu_result;
    assign o_rd_m         = ex_mem_reg.rd;
    assign o_reg_write_m  = ex_mem_reg.reg_write & ex_mem_reg.valid;
    assign o_stall_m      = stall;
    assign o_misalign_m   = misalign_pulse;
    assign o_bus_err_m    = bus_err;

    assign o_dmem_req     = req;
    assign o_dmem_we      = ex_mem_reg.mem_write;
    assign o_dmem_addr    = {ex_mem_reg.alu_result[XLEN-1:2], 2'b00};
    assign o_dmem_be      = be;
    assign o_dmem_wdata   = wdata;

    assign o_valid_w      = mem_wb_reg.valid;
    assign o_reg_write_w  = mem_wb_reg.reg_write;
    assign o_rd_w         = mem_wb_reg.rd;
    assign o_result_src_w = mem_wb_reg.result_src;
    assign o_alu_result_w = mem_wb_reg.alu_result;
    assign o_read_data_w  = mem_wb_reg.read_data;
    assign o_pc_plus4_w   = mem_wb_reg.pc_plus4;

endmodule
